keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_if.sv | 31 +++
 rtl/keypad_scanner.sv | 219 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix row/column lines plus the
// key-code handshake toward the consumer.
interface keypad_scanner_if;
  logic [3:0] Rows;
  logic [3:0] Cols;
  logic       KeyAck;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyHeld;
  logic       Overrun;

  modport master (
    input  Rows,
    input  KeyAck,
    output Cols,
    output KeyCode,
    output KeyValid,
    output KeyHeld,
    output Overrun
  );

  modport slave (
    output Rows,
    output KeyAck,
    input  Cols,
    input  KeyCode,
    input  KeyValid,
    input  KeyHeld,
    input  Overrun
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks one active-low column at a time, debounces the
// first row seen low and hands the confirmed key to the consumer with a
// valid/ack handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------
// SCAN     | rotating columns, waiting for any row to go low
// DEBOUNCE | column frozen, counting ticks the captured row stays low
// HELD     | key confirmed, waiting for the captured row to go high
// RELEASE  | counting ticks the captured row stays high before rescanning
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input logic             Clk,
  input logic             Reset,
  keypad_scanner_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       rows_m;
  logic [3:0]       rows_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       cols;
  logic [1:0]       col_idx;
  logic [1:0]       cap_row;
  logic [1:0]       cap_col;
  logic [DB_W-1:0]  db_cnt;
  logic             db_last;
  logic [1:0]       low_row;
  logic             cap_low;
  logic             any_low;
  logic [3:0]       key_code;
  logic             key_valid;
  logic             key_held;
  logic             overrun;
  logic             do_rotate;
  logic             do_capture;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             do_confirm;

  assign tick    = (div_cnt == DIV_LAST);
  assign cap_low = ~rows_s[cap_row];
  assign any_low = (rows_s != 4'hF);
  assign db_last = (db_cnt == DB_LAST);

  // Row returns are asynchronous to Clk; double-flop them before use.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rows_m <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      rows_m <= kp.Rows;
      rows_s <= rows_m;
    end
  end

  // Free-running scan divider producing a one-cycle tick per column dwell.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Lowest-numbered row currently pulled low.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s[i]) low_row = 2'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_SCAN;
    else       state <= state_nxt;
  end

  // FSM next-state decode; rows are only looked at on tick cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SCAN: begin
        if (tick && any_low) state_nxt = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (!cap_low)     state_nxt = ST_SCAN;
          else if (db_last) state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (tick && !cap_low) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (tick) begin
          if (cap_low)      state_nxt = ST_HELD;
          else if (db_last) state_nxt = ST_SCAN;
        end
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  // FSM output decode: datapath strobes and the held indicator.
  always_comb begin
    do_rotate  = 1'b0;
    do_capture = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    do_confirm = 1'b0;
    key_held   = (state == ST_HELD) || (state == ST_RELEASE);
    case (state)
      ST_SCAN: begin
        if (tick) begin
          if (any_low) begin
            do_capture = 1'b1;
            cnt_clr    = 1'b1;
          end else begin
            do_rotate = 1'b1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (cap_low) begin
            cnt_inc    = 1'b1;
            do_confirm = db_last;
          end else begin
            do_rotate = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (tick && !cap_low) cnt_clr = 1'b1;
      end
      ST_RELEASE: begin
        if (tick) begin
          if (cap_low) begin
            cnt_clr = 1'b1;
          end else begin
            cnt_inc   = 1'b1;
            do_rotate = db_last;
          end
        end
      end
      default: ;
    endcase
  end

  // Column driver, key capture and the shared debounce/release counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cols    <= 4'hE;
      col_idx <= 2'd0;
      cap_row <= 2'd0;
      cap_col <= 2'd0;
      db_cnt  <= '0;
    end else begin
      if (do_rotate) begin
        cols    <= {cols[2:0], cols[3]};
        col_idx <= col_idx + 2'd1;
      end
      if (do_capture) begin
        cap_row <= low_row;
        cap_col <= col_idx;
      end
      if (cnt_clr)      db_cnt <= '0;
      else if (cnt_inc) db_cnt <= db_cnt + 1'b1;
    end
  end

  // Consumer handshake; an accepted ack wins over overrun and keeps a
  // same-cycle confirm as the new pending key.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (kp.KeyAck && key_valid) begin
      overrun <= 1'b0;
      if (do_confirm) key_code  <= {cap_row, cap_col};
      else            key_valid <= 1'b0;
    end else if (do_confirm) begin
      if (key_valid) begin
        overrun <= 1'b1;
      end else begin
        key_code  <= {cap_row, cap_col};
        key_valid <= 1'b1;
      end
    end
  end

  assign kp.Cols     = cols;
  assign kp.KeyCode  = key_code;
  assign kp.KeyValid = key_valid;
  assign kp.KeyHeld  = key_held;
  assign kp.Overrun  = overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural keypad matrix drives Rows from the
// pressed-key set and the active column; expected key codes go into a
// scoreboard queue when presses are issued and a monitor pops them whenever
// the DUT presents a new key.
module tb_keypad_scanner;
  localparam int S = 4;
  localparam int D = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] pressed;
  logic [3:0]  rows_drv;
  logic        ack_dir;
  logic        ack_mon;
  logic        auto_ack;
  int          vectors;
  int          miscompares;
  logic [3:0]  sb[$];
  logic        mon_prev_v;
  logic [3:0]  mon_prev_c;
  int          mon_ack_wait;
  logic [3:0]  mon_exp;

  always #5 Clk = ~Clk;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_TICKS(D)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .kp    (kif)
  );

  // Key at index r*4+c shorts row r to column c while that column is driven low.
  always_comb begin
    rows_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.Cols[c]) rows_drv[r] = 1'b0;
  end

  assign kif.Rows   = rows_drv;
  assign kif.KeyAck = ack_dir | ack_mon;

  function automatic logic [3:0] col_pat(int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (k % 4));
  endfunction

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_cols(logic [3:0] v, bit eq, int budget, string nm);
    int n;
    n = 0;
    while (((kif.Cols == v) != eq) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk(nm, int'((kif.Cols == v) == eq), 1);
  endtask

  task automatic wait_held(logic lvl, int budget, string nm);
    int n;
    n = 0;
    while (kif.KeyHeld != lvl && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk(nm, int'(kif.KeyHeld), int'(lvl));
  endtask

  task automatic ack_pulse();
    ack_dir = 1'b1;
    @(negedge Clk);
    ack_dir = 1'b0;
  endtask

  // Monitor: every new key presentation is checked against the scoreboard.
  initial begin
    mon_prev_v   = 1'b0;
    mon_prev_c   = 4'h0;
    mon_ack_wait = 0;
    ack_mon      = 1'b0;
    forever begin
      @(negedge Clk);
      ack_mon = 1'b0;
      if (mon_ack_wait > 0) begin
        mon_ack_wait--;
        if (mon_ack_wait == 0) ack_mon = 1'b1;
      end
      if (kif.KeyValid && (!mon_prev_v || kif.KeyCode != mon_prev_c)) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_key: got 0x%0h, want no key at %0t", kif.KeyCode, $time);
        end else begin
          mon_exp = sb.pop_front();
          chk("key_code", int'(kif.KeyCode), int'(mon_exp));
          if (auto_ack) begin
            chk("overrun_idle", int'(kif.Overrun), 0);
            mon_ack_wait = $urandom_range(1, 3);
          end
        end
      end
      mon_prev_v = kif.KeyValid;
      mon_prev_c = kif.KeyCode;
    end
  end

  initial begin
    int k;
    int len;
    bit bounce;
    vectors     = 0;
    miscompares = 0;
    pressed     = '0;
    ack_dir     = 1'b0;
    auto_ack    = 1'b0;
    Reset       = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);

    chk("rst_cols", int'(kif.Cols), 4'hE);
    chk("rst_valid", int'(kif.KeyValid), 0);
    chk("rst_code", int'(kif.KeyCode), 0);
    chk("rst_held", int'(kif.KeyHeld), 0);
    chk("rst_overrun", int'(kif.Overrun), 0);
    Reset = 1'b0;

    // Idle rotation: each column pattern held exactly S cycles.
    for (int i = 0; i < 40; i++) begin
      chk("idle_cols", int'(kif.Cols), int'(col_pat(i / S)));
      chk("idle_valid", int'(kif.KeyValid), 0);
      @(negedge Clk);
    end

    // Row 2 / column 2 held for 20 ticks.
    pressed[2*4+2] = 1'b1;
    sb.push_back(4'hA);
    repeat (20*S) @(negedge Clk);
    chk("held_valid", int'(kif.KeyValid), 1);
    chk("held_code", int'(kif.KeyCode), 4'hA);
    chk("held_held", int'(kif.KeyHeld), 1);
    chk("held_cols", int'(kif.Cols), 4'hB);
    pressed = '0;
    wait_cols(4'hB, 1'b0, (D+3)*S, "release_resume");
    chk("release_cols", int'(kif.Cols), 4'h7);
    chk("release_held", int'(kif.KeyHeld), 0);
    ack_pulse();
    chk("ack_clears_valid", int'(kif.KeyValid), 0);

    // Bounce: row 1 low under column 0 for two ticks only.
    wait_cols(4'hE, 1'b0, 5*S, "bounce_sync_a");
    wait_cols(4'hE, 1'b1, 5*S, "bounce_sync_b");
    pressed[1*4+0] = 1'b1;
    repeat (2*S) @(negedge Clk);
    pressed = '0;
    wait_cols(4'hE, 1'b0, (D+2)*S, "bounce_resume");
    chk("bounce_cols", int'(kif.Cols), 4'hD);
    chk("bounce_valid", int'(kif.KeyValid), 0);

    // Overrun: key 5 left pending, then key 0 confirmed.
    pressed[5] = 1'b1;
    sb.push_back(4'h5);
    wait_held(1'b1, (D+5)*S+4, "k5_confirm");
    pressed = '0;
    wait_held(1'b0, (D+3)*S, "k5_release");
    pressed[0] = 1'b1;
    wait_held(1'b1, (D+5)*S+4, "k0_confirm");
    repeat (2) @(negedge Clk);
    chk("ovr_flag", int'(kif.Overrun), 1);
    chk("ovr_code", int'(kif.KeyCode), 4'h5);
    chk("ovr_valid", int'(kif.KeyValid), 1);
    pressed = '0;
    wait_held(1'b0, (D+3)*S, "k0_release");
    ack_pulse();
    chk("ovr_ack_valid", int'(kif.KeyValid), 0);
    chk("ovr_ack_flag", int'(kif.Overrun), 0);

    // Ack landing in the same cycle as a new confirm.
    pressed[3] = 1'b1;
    sb.push_back(4'h3);
    wait_held(1'b1, (D+5)*S+4, "k3_confirm");
    pressed = '0;
    wait_held(1'b0, (D+3)*S, "k3_release");
    wait_cols(4'hB, 1'b0, 5*S, "same_sync_a");
    pressed[14] = 1'b1;
    wait_cols(4'hB, 1'b1, 5*S, "same_sync_b");
    sb.push_back(4'hE);
    repeat ((D+1)*S - 1) @(posedge Clk);
    @(negedge Clk);
    ack_dir = 1'b1;
    @(negedge Clk);
    ack_dir = 1'b0;
    chk("same_valid", int'(kif.KeyValid), 1);
    chk("same_code", int'(kif.KeyCode), 4'hE);
    chk("same_overrun", int'(kif.Overrun), 0);
    chk("same_held", int'(kif.KeyHeld), 1);
    pressed = '0;
    wait_held(1'b0, (D+3)*S, "kE_release");

    // Reset mid-debounce with a key still pending and ack asserted.
    wait_cols(4'h7, 1'b0, 5*S, "rst_sync_a");
    wait_cols(4'h7, 1'b1, 5*S, "rst_sync_b");
    pressed[7] = 1'b1;
    repeat (S+2) @(negedge Clk);
    chk("mid_cols", int'(kif.Cols), 4'h7);
    Reset   = 1'b1;
    ack_dir = 1'b1;
    pressed = '0;
    @(negedge Clk);
    Reset   = 1'b0;
    ack_dir = 1'b0;
    chk("mid_rst_cols", int'(kif.Cols), 4'hE);
    chk("mid_rst_valid", int'(kif.KeyValid), 0);
    chk("mid_rst_held", int'(kif.KeyHeld), 0);
    chk("mid_rst_overrun", int'(kif.Overrun), 0);
    chk("mid_rst_code", int'(kif.KeyCode), 0);

    // Random presses: long ones must be reported, short bounces never.
    auto_ack = 1'b1;
    for (int it = 0; it < 16; it++) begin
      k      = $urandom_range(0, 15);
      bounce = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 4*S)) @(negedge Clk);
      if (bounce) len = $urandom_range(1, (D-1)*S);
      else        len = (D+6)*S + $urandom_range(0, 3*S);
      pressed[k] = 1'b1;
      if (!bounce) sb.push_back(4'(k));
      repeat (len) @(negedge Clk);
      pressed = '0;
      repeat ((D+4)*S + $urandom_range(0, S)) @(negedge Clk);
    end
    repeat (2*S) @(negedge Clk);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
